// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the fetch/data memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned ARB_ADDR_W     = 8;
    localparam int unsigned ARB_STARVE_MAX = 3;
    localparam int unsigned ARB_DATA_W     = 32;
    localparam int unsigned ARB_STRB_W     = ARB_DATA_W / 8;

    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_IF_RD = 2'd1,
        OWN_DM_RD = 2'd2
    } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles a requester was refused; at_max flags the limit.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter  int unsigned MAX   = ARB_STARVE_MAX,
    localparam int unsigned CNT_W = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [CNT_W-1:0] cnt;

    assign at_max = (cnt == CNT_W'(MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory between fetch (read-only) and data (read/write);
// data has priority unless fetch has been refused STARVE_MAX cycles in a row.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ARB_ADDR_W,
    parameter int unsigned STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  if__req,
    input  logic [ADDR_W-1:0]     if__addr,
    output logic                  if__gnt,
    output logic                  if__rvalid,
    output logic [ARB_DATA_W-1:0] if__rdata,
    input  logic                  dm__req,
    input  logic                  dm__we,
    input  logic [ADDR_W-1:0]     dm__addr,
    input  logic [ARB_DATA_W-1:0] dm__wdata,
    input  logic [ARB_STRB_W-1:0] dm__wstrb,
    output logic                  dm__gnt,
    output logic                  dm__rvalid,
    output logic [ARB_DATA_W-1:0] dm__rdata,
    output logic                  mem__en,
    output logic [ARB_STRB_W-1:0] mem__we,
    output logic [ADDR_W-1:0]     mem__addr,
    output logic [ARB_DATA_W-1:0] mem__wdata,
    input  logic [ARB_DATA_W-1:0] mem__rdata
);

    owner_t owner_q;
    owner_t owner_d;
    logic   kill_q;
    logic   at_max;
    logic   fetch_win;

    // Fetch wins when data is idle or fetch has waited long enough.
    assign fetch_win = if__req && (!dm__req || at_max);
    assign if__gnt   = rst_n && fetch_win;
    assign dm__gnt   = rst_n && dm__req && !fetch_win;

    arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (if__req && !if__gnt),
        .clr    (!if__req || if__gnt),
        .at_max (at_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_IDLE;
            kill_q  <= 1'b0;
        end else begin
            owner_q <= owner_d;
            kill_q  <= flush;
        end
    end

    // Next owner and memory drive for the granted access.
    always_comb begin
        owner_d    = OWN_IDLE;
        mem__en    = 1'b0;
        mem__we    = '0;
        mem__addr  = if__addr;
        mem__wdata = dm__wdata;
        if (if__gnt) begin
            owner_d = OWN_IF_RD;
            mem__en = 1'b1;
        end else if (dm__gnt) begin
            mem__en   = 1'b1;
            mem__addr = dm__addr;
            if (dm__we) begin
                mem__we = dm__wstrb;
            end else begin
                owner_d = OWN_DM_RD;
            end
        end
    end

    // A flush hides fetch data both in its own cycle and in the cycle after.
    assign if__rvalid = rst_n && (owner_q == OWN_IF_RD) && !kill_q && !flush;
    assign dm__rvalid = rst_n && (owner_q == OWN_DM_RD);
    assign if__rdata  = mem__rdata;
    assign dm__rdata  = mem__rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned SM = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          if__req = 1'b0;
    logic [AW-1:0] if__addr = '0;
    logic          if__gnt;
    logic          if__rvalid;
    logic [31:0]   if__rdata;
    logic          dm__req = 1'b0;
    logic          dm__we = 1'b0;
    logic [AW-1:0] dm__addr = '0;
    logic [31:0]   dm__wdata = '0;
    logic [3:0]    dm__wstrb = '0;
    logic          dm__gnt;
    logic          dm__rvalid;
    logic [31:0]   dm__rdata;
    logic          mem__en;
    logic [3:0]    mem__we;
    logic [AW-1:0] mem__addr;
    logic [31:0]   mem__wdata;
    logic [31:0]   mem__rdata;

    mem_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .if__req(if__req), .if__addr(if__addr), .if__gnt(if__gnt),
        .if__rvalid(if__rvalid), .if__rdata(if__rdata),
        .dm__req(dm__req), .dm__we(dm__we), .dm__addr(dm__addr),
        .dm__wdata(dm__wdata), .dm__wstrb(dm__wstrb), .dm__gnt(dm__gnt),
        .dm__rvalid(dm__rvalid), .dm__rdata(dm__rdata),
        .mem__en(mem__en), .mem__we(mem__we), .mem__addr(mem__addr),
        .mem__wdata(mem__wdata), .mem__rdata(mem__rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 5) ? 32'h1122_3344 : 32'(i);
    endfunction

    // Memory macro driven by the DUT's memory port.
    logic [31:0] mac_mem [256];
    logic        mac_loaded = 1'b0;
    logic [31:0] mac_rdata = '0;
    always @(posedge clk) begin
        if (!mac_loaded) begin
            for (int i = 0; i < 256; i++) mac_mem[i] <= init_word(i);
            mac_loaded <= 1'b1;
        end else if (mem__en) begin
            for (int b = 0; b < 4; b++)
                if (mem__we[b]) mac_mem[mem__addr][8*b +: 8] <= mem__wdata[8*b +: 8];
            mac_rdata <= mac_mem[mem__addr];
        end
    end
    assign mem__rdata = mac_rdata;

    // Reference model: shadow memory, refused-fetch run length, pending response.
    logic [31:0] ref_mem [256];
    int          lost = 0;
    int          pend_kind = 0;   // 0 none, 1 fetch, 2 data read
    logic [31:0] pend_data = '0;
    bit          pend_killed = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    bit          got_if_gnt, got_dm_gnt, got_if_rvalid, got_dm_rvalid;
    logic [3:0]  got_mem_we;
    logic [31:0] got_if_rdata, got_dm_rdata;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        lost        = 0;
        pend_kind   = 0;
        pend_killed = 1'b0;
    endtask

    // One clock: drive at negedge, check combinational/response outputs, advance the model at posedge.
    task automatic step(input bit ir, input logic [7:0] ia, input bit dr, input bit dw,
                        input logic [7:0] da, input logic [31:0] wd, input logic [3:0] ws,
                        input bit fl);
        bit exp_if, exp_dm, exp_ifv, exp_dmv;
        @(negedge clk);
        if__req = ir; if__addr = ia; dm__req = dr; dm__we = dw; dm__addr = da;
        dm__wdata = wd; dm__wstrb = ws; flush = fl;
        #1;
        exp_if  = rst_n && ir && (!dr || lost >= int'(SM));
        exp_dm  = rst_n && dr && !exp_if;
        exp_ifv = rst_n && pend_kind == 1 && !pend_killed && !fl;
        exp_dmv = rst_n && pend_kind == 2;
        got_if_gnt = if__gnt; got_dm_gnt = dm__gnt; got_mem_we = mem__we;
        got_if_rvalid = if__rvalid; got_dm_rvalid = dm__rvalid;
        got_if_rdata = if__rdata; got_dm_rdata = dm__rdata;
        check_eq("if_gnt", 64'(if__gnt), 64'(exp_if));
        check_eq("dm_gnt", 64'(dm__gnt), 64'(exp_dm));
        check_eq("mem_en", 64'(mem__en), 64'(exp_if || exp_dm));
        check_eq("mem_we", 64'(mem__we), 64'((exp_dm && dw) ? ws : 4'h0));
        if (exp_if) check_eq("mem_addr_if", 64'(mem__addr), 64'(ia));
        if (exp_dm) check_eq("mem_addr_dm", 64'(mem__addr), 64'(da));
        if (exp_dm && dw) check_eq("mem_wdata", 64'(mem__wdata), 64'(wd));
        check_eq("if_rvalid", 64'(if__rvalid), 64'(exp_ifv));
        check_eq("dm_rvalid", 64'(dm__rvalid), 64'(exp_dmv));
        if (exp_ifv) check_eq("if_rdata", 64'(if__rdata), 64'(pend_data));
        if (exp_dmv) check_eq("dm_rdata", 64'(dm__rdata), 64'(pend_data));
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            pend_kind   = exp_if ? 1 : ((exp_dm && !dw) ? 2 : 0);
            pend_data   = ref_mem[exp_if ? ia : da];
            pend_killed = fl;
            if (exp_dm && dw)
                for (int b = 0; b < 4; b++)
                    if (ws[b]) ref_mem[da][8*b +: 8] = wd[8*b +: 8];
            lost = (ir && !exp_if) ? lost + 1 : 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h0, 0, 0, 8'h0, 32'h0, 4'h0, 0);
    endtask

    // Asynchronous reset pulse inside the high phase, just after a posedge.
    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_if_gnt", 64'(if__gnt), 64'(0));
        check_eq("rst_dm_gnt", 64'(dm__gnt), 64'(0));
        check_eq("rst_mem_en", 64'(mem__en), 64'(0));
        check_eq("rst_mem_we", 64'(mem__we), 64'(0));
        check_eq("rst_if_rvalid", 64'(if__rvalid), 64'(0));
        check_eq("rst_dm_rvalid", 64'(dm__rvalid), 64'(0));
        model_clear();
        #1 rst_n = 1'b1;
    endtask

    task automatic contention(input string tag, input int n);
        bit exp_pat [8];
        exp_pat = '{0, 0, 0, 1, 0, 0, 0, 1};
        for (int i = 0; i < n; i++) begin
            step(1, 8'h40, 1, 0, 8'h41, 32'h0, 4'h0, 0);
            check_eq(tag, 64'(got_if_gnt), 64'(exp_pat[i]));
        end
    endtask

    initial begin
        bit          ip, dp, dw, fl;
        logic [7:0]  ia, da;
        logic [31:0] wd;
        logic [3:0]  ws;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        // Reset held with requests pending: nothing may be granted.
        step(1, 8'h01, 1, 0, 8'h02, 32'h0, 4'h0, 0);
        step(1, 8'h01, 1, 1, 8'h02, 32'h0, 4'hF, 0);
        @(negedge clk); #2 rst_n = 1'b1;

        // Fetch stream with one-cycle read latency.
        step(1, 8'h10, 0, 0, 8'h0, 32'h0, 4'h0, 0);
        step(1, 8'h11, 0, 0, 8'h0, 32'h0, 4'h0, 0);
        check_eq("fetch_rdata0", 64'(got_if_rdata), 64'(32'h10));
        step(1, 8'h12, 0, 0, 8'h0, 32'h0, 4'h0, 0);
        check_eq("fetch_rdata1", 64'(got_if_rdata), 64'(32'h11));
        idle(1);
        check_eq("fetch_rdata2", 64'(got_if_rdata), 64'(32'h12));

        // Starvation: DM,DM,DM,IF repeating.
        idle(1);
        contention("cont_pat", 8);

        // Partial write followed by read-back.
        idle(1);
        step(0, 8'h0, 1, 1, 8'h05, 32'hAABB_CCDD, 4'b0011, 0);
        check_eq("wr_mem_we", 64'(got_mem_we), 64'(4'b0011));
        step(0, 8'h0, 1, 0, 8'h05, 32'h0, 4'h0, 0);
        check_eq("wr_no_rvalid", 64'(got_dm_rvalid), 64'(0));
        idle(1);
        check_eq("wr_rd_valid", 64'(got_dm_rvalid), 64'(1));
        check_eq("wr_merge", 64'(got_dm_rdata), 64'(32'h1122_CCDD));

        // Flush kills the in-flight fetch and the one granted during flush.
        step(1, 8'h20, 0, 0, 8'h0, 32'h0, 4'h0, 0);
        step(1, 8'h21, 0, 0, 8'h0, 32'h0, 4'h0, 1);
        check_eq("flush_n1", 64'(got_if_rvalid), 64'(0));
        idle(1);
        check_eq("flush_n2", 64'(got_if_rvalid), 64'(0));

        // Async reset while a data read is outstanding.
        step(0, 8'h0, 1, 0, 8'h30, 32'h0, 4'h0, 0);
        step(1, 8'h31, 1, 0, 8'h30, 32'h0, 4'h0, 0);
        reset_pulse();
        idle(1);
        check_eq("rst_drop", 64'(got_dm_rvalid), 64'(0));
        contention("rst_cont_pat", 4);

        // Idle stretch.
        idle(5);

        // Randomized traffic with hold-until-grant requesters.
        ip = 0; dp = 0; ia = '0; da = '0; dw = 0; wd = '0; ws = '0;
        for (int c = 0; c < 600; c++) begin
            if (!ip || $urandom_range(0, 15) == 0) begin
                ip = $urandom_range(0, 2) != 0;
                ia = 8'($urandom);
            end
            if (!dp || $urandom_range(0, 15) == 0) begin
                dp = $urandom_range(0, 3) != 0;
                dw = $urandom_range(0, 2) == 0;
                da = 8'($urandom_range(0, 31));
                wd = $urandom;
                ws = 4'($urandom);
            end
            fl = $urandom_range(0, 9) == 0;
            step(ip, ia, dp, dw, da, wd, ws, fl);
            if (got_if_gnt) ip = 0;
            if (got_dm_gnt) dp = 0;
            if ($urandom_range(0, 99) == 0) reset_pulse();
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
